// File: rtl/serial_adder_if.sv
// serial_adder_if
// Groups the operand request and result signals of the bit-serial adder.
//   i_start / i_a / i_b / i_cin : request a new addition and its operands
//   o_busy / o_done             : activity flag and one-cycle result strobe
//   o_sum / o_cout              : parallel result, held until the next accepted start
//   o_bit_valid / o_sum_bit     : serial sum stream, LSB first, one bit per RUN cycle
// The master modport belongs to whoever issues requests; the adder uses slave.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_bit_valid;
    logic             o_sum_bit;

    modport master (
        output i_start, i_a, i_b, i_cin,
        input  o_busy, o_done, o_sum, o_cout, o_bit_valid, o_sum_bit
    );

    modport slave (
        input  i_start, i_a, i_b, i_cin,
        output o_busy, o_done, o_sum, o_cout, o_bit_valid, o_sum_bit
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial adder around a single full-adder cell. Operands are loaded on an
// accepted start, walked LSB first through the cell one bit per clock with the
// carry registered and fed back, and the sum bits are collected into a parallel
// result together with the final carry.
//   i_clk : clock, rising edge
//   i_rst : asynchronous, active-high reset
//   bus   : serial_adder_if slave (request, operands, results, serial stream)
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for i_start; previous result held on o_sum/o_cout
// S_RUN  | one operand bit per cycle through the full-adder cell
// S_DONE | result valid, o_done high for this single cycle
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    serial_adder_if.slave bus
);
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] sum_shift;
    logic             carry_r;
    logic             cout_r;
    logic [CW-1:0]    cnt;
    logic             fa_a;
    logic             fa_b;
    logic             fa_s;
    logic             fa_co;
    logic             load;
    logic             run;
    logic             last;

    // Full-adder cell
    assign fa_a  = a_sr[0];
    assign fa_b  = b_sr[0];
    assign fa_s  = fa_a ^ fa_b ^ carry_r;
    assign fa_co = (fa_a & fa_b) | ((fa_a ^ fa_b) & carry_r);

    // New sum bit enters from the MSB side so that after WIDTH shifts the
    // first (LSB) bit has reached position 0.
    generate
        if (WIDTH > 1) begin : g_shift_wide
            assign sum_shift = {fa_s, sum_r[WIDTH-1:1]};
        end else begin : g_shift_one
            assign sum_shift = fa_s;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        run       = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    load      = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                run = 1'b1;
                if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            a_sr    <= bus.i_a;
            b_sr    <= bus.i_b;
            carry_r <= bus.i_cin;
            sum_r   <= '0;
            cout_r  <= 1'b0;
            cnt     <= '0;
        end else if (run) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_r   <= sum_shift;
            carry_r <= fa_co;
            cnt     <= cnt + CW'(1);
            if (last) begin
                cout_r <= fa_co;
            end
        end
    end

    assign bus.o_busy      = (state != S_IDLE);
    assign bus.o_done      = (state == S_DONE);
    assign bus.o_sum       = sum_r;
    assign bus.o_cout      = cout_r;
    assign bus.o_bit_valid = (state == S_RUN);
    assign bus.o_sum_bit   = (state == S_RUN) ? fa_s : 1'b0;
endmodule
